// File: rtl/uart_tx_param_if.sv
// Transmit handshake bundle for uart_tx_param.
// Signals:
//   tx_valid - source presents a word on tx_data
//   tx_data  - word to transmit, bit 0 goes out first
//   tx_ready - transmitter can take a word this cycle
// Modports: master (word source), slave (transmitter).
interface uart_tx_param_if #(
   parameter int unsigned DATA_W = 8
);
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional
// even/odd parity, STOP_BITS stop bits, each bit lasting CLK_DIV clocks.
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry queue in front of the
// FSM (tx_ready = not full, frames run back to back). Without it a single holding
// register is used and tx_ready is high only while idle.
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - asynchronous active-high reset
//   tx_if        - handshake bundle (slave modport): tx_valid, tx_data, tx_ready
//   serial_out_o - registered UART line, idle high
//   busy_o       - frame in progress or word queued
module uart_tx_param #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CLK_DIV     = 5208,
   parameter int unsigned PARITY_MODE = 1,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic           clk_i,
   input  logic           reset_i,
   uart_tx_param_if.slave tx_if,
   output logic           serial_out_o,
   output logic           busy_o
);

   if (DATA_W < 5 || DATA_W > 9 || CLK_DIV < 2 || PARITY_MODE > 2 || STOP_BITS < 1 ||
       STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_bad_param
      $error("uart_tx_param: illegal parameter value");
   end

   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam int unsigned BitW = $clog2(DATA_W);
   localparam logic [DivW-1:0] DivLoad  = DivW'(CLK_DIV - 1);
   localparam logic [BitW-1:0] LastData = BitW'(DATA_W - 1);
   localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);
   localparam bit HasParity = (PARITY_MODE != 0);
   localparam bit OddParity = (PARITY_MODE == 2);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              line_q, line_d;

   logic              word_avail;
   logic [DATA_W-1:0] word_next;
   logic              load;
   logic              tick;

`ifdef UART_TX_FIFO_EN
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW:0]     wr_q, rd_q;
   logic              empty, full, push;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty          = (wr_q == rd_q);
   assign full           = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
   assign push           = tx_if.tx_valid & ~full;
   assign tx_if.tx_ready = ~full;
   assign word_avail     = ~empty;
   assign word_next      = mem_q[rd_q[PtrW-1:0]];
   assign busy_o         = (state_q != StIdle) | ~empty;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (load) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q[PtrW-1:0]] <= tx_if.tx_data;
   end
`else
   assign tx_if.tx_ready = (state_q == StIdle);
   assign word_avail     = tx_if.tx_valid & (state_q == StIdle);
   assign word_next      = tx_if.tx_data;
   assign busy_o         = (state_q != StIdle);
`endif

   assign tick         = (div_q == '0);
   assign serial_out_o = line_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      line_d  = line_q;
      load    = 1'b0;

      if (state_q != StIdle) div_d = tick ? DivLoad : div_q - 1'b1;

      unique case (state_q)
         StIdle: begin
            if (word_avail) load = 1'b1;
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               line_d  = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         StData: begin
            if (tick) begin
               if (bit_q == LastData) begin
                  bit_d = '0;
                  if (HasParity) begin
                     state_d = StParity;
                     line_d  = par_q;
                  end else begin
                     state_d = StStop;
                     line_d  = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  line_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParity: begin
            if (tick) begin
               state_d = StStop;
               line_d  = 1'b1;
               bit_d   = '0;
            end
         end
         StStop: begin
            if (tick) begin
               if (bit_q == LastStop) begin
                  // A queued word goes straight into its start bit, no idle bit between.
                  if (word_avail) begin
                     load = 1'b1;
                  end else begin
                     state_d = StIdle;
                     div_d   = '0;
                     bit_d   = '0;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Start of a frame: capture the word and its parity, drive the start bit.
      if (load) begin
         state_d = StStart;
         div_d   = DivLoad;
         bit_d   = '0;
         line_d  = 1'b0;
         shift_d = word_next;
         par_d   = (^word_next) ^ OddParity;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         line_q  <= line_d;
      end
   end

endmodule
